wb_clint: RTL

- Wishbone B4 pipelined slave: the responder end of the core's data-memory Wishbone master.
- Implements the machine timer and software-interrupt registers: mtime, mtimecmp and msip.
- Drives the core's mtip_i and msip_i interrupt inputs.
- Sits on the data bus behind the external address decoder, which asserts stb only for this block's window.

---
 rtl/wb_clint_if.sv | 25 ++
 rtl/wb_clint.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/wb_clint_if.sv
// Wishbone B4 pipelined bus bundle between the data-memory master and wb_clint.
//   master modport : drives cyc/stb/we/adr/dat_i/sel, samples stall/ack/err/dat_o
//   slave modport  : the reverse view, used by wb_clint
interface wb_clint_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] wb_dat_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );
endinterface

// File: rtl/wb_clint.sv
// Core-local interruptor: machine timer (mtime/mtimecmp) and software
// interrupt (msip) registers behind a Wishbone B4 pipelined slave port.
//   wb_clk_i / wb_rst_i : clock, asynchronous active-high reset
//   wb (slave)          : bus requests in, single-cycle-latency ack/err/data out
//   mtip_o              : timer interrupt pending (mtime >= mtimecmp)
//   msip_o              : software interrupt pending (msip bit0)
module wb_clint #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  wb_clint_if.slave   wb,
  output logic        mtip_o,
  output logic        msip_o
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] OFF_MSIP    = 3'd0;
  localparam logic [2:0] OFF_CMP_LO  = 3'd2;
  localparam logic [2:0] OFF_CMP_HI  = 3'd3;
  localparam logic [2:0] OFF_TIME_LO = 3'd4;
  localparam logic [2:0] OFF_TIME_HI = 3'd5;

  logic [CNT_W-1:0] r_pre;
  logic [63:0]      r_mtime;
  logic [63:0]      r_mtimecmp;
  logic             r_msip;

  logic        w_acc;
  logic        w_wr;
  logic        w_map;
  logic        w_tick;
  logic [2:0]  w_off;
  logic [31:0] w_rdata;
  logic [63:0] w_mtime_nxt;
  logic        w_unused;

  // Replace only the byte lanes enabled in sel
  function automatic logic [31:0] f_merge(input logic [31:0] cur,
                                          input logic [31:0] wdat,
                                          input logic [3:0]  sel);
    f_merge = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) f_merge[8*i +: 8] = wdat[8*i +: 8];
    end
  endfunction

  assign w_acc    = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_wr     = w_acc & wb.wb_we_i;
  assign w_off    = wb.wb_adr_i[4:2];
  assign w_tick   = (r_pre == CNT_W'(PRESCALE - 1));
  assign w_unused = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

  assign wb.wb_stall_o = 1'b0;

  // Address decode and read mux; unmapped offsets read as zero
  always_comb begin
    w_map   = 1'b0;
    w_rdata = '0;
    case (w_off)
      OFF_MSIP:    begin w_map = 1'b1; w_rdata = {31'd0, r_msip}; end
      OFF_CMP_LO:  begin w_map = 1'b1; w_rdata = r_mtimecmp[31:0];  end
      OFF_CMP_HI:  begin w_map = 1'b1; w_rdata = r_mtimecmp[63:32]; end
      OFF_TIME_LO: begin w_map = 1'b1; w_rdata = r_mtime[31:0];     end
      OFF_TIME_HI: begin w_map = 1'b1; w_rdata = r_mtime[63:32];    end
      default:     begin w_map = 1'b0; w_rdata = '0;                end
    endcase
  end

  // A write to either mtime word wins over the increment; the other word holds
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr && (w_off == OFF_TIME_LO)) begin
      w_mtime_nxt[31:0] = f_merge(r_mtime[31:0], wb.wb_dat_i, wb.wb_sel_i);
    end else if (w_wr && (w_off == OFF_TIME_HI)) begin
      w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], wb.wb_dat_i, wb.wb_sel_i);
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end
  end

  // Prescaler: free-running, unaffected by bus writes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + CNT_W'(1);
    end
  end

  // Architectural registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      r_mtime <= w_mtime_nxt;
      if (w_wr && (w_off == OFF_CMP_LO)) begin
        r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], wb.wb_dat_i, wb.wb_sel_i);
      end
      if (w_wr && (w_off == OFF_CMP_HI)) begin
        r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], wb.wb_dat_i, wb.wb_sel_i);
      end
      if (w_wr && (w_off == OFF_MSIP) && wb.wb_sel_i[0]) begin
        r_msip <= wb.wb_dat_i[0];
      end
    end
  end

  // Bus response, one cycle after acceptance; read data captured pre-update
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= w_acc & w_map;
      wb.wb_err_o <= w_acc & ~w_map;
      if (w_acc && !wb.wb_we_i) begin
        wb.wb_dat_o <= w_rdata;
      end
    end
  end

  // Interrupt outputs from current register values
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mtip_o <= 1'b0;
      msip_o <= 1'b0;
    end else begin
      mtip_o <= (r_mtime >= r_mtimecmp);
      msip_o <= r_msip;
    end
  end

endmodule
